bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Serial-bus arbiter that shares the single serial bus among NUM_MASTERS master modules. It grants the bus round-robin and captures the serially shifted slave select from the granted master. It then decodes that select into a one-hot slave enable, holds the connection until the owner reports transaction completion, and releases the bus. It sits between the master modules' approval/busy pins and the slave-side enable inputs of the bus interconnect.

## Interface
- NUM_MASTERS, 2, number of requesting masters (≥2); OWN_W = $clog2(NUM_MASTERS)
- SLAVE_LEN, 2, width of serial slave select; NUM_SLAVES = 2**SLAVE_LEN
- TIMEOUT, 1024, max CONNECT cycles before forced release; 0 disables timeout
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- approval_request  in  NUM_MASTERS  per-master bus request, level, held until trans_done
- tx_slave_select  in  NUM_MASTERS  per-master serial slave select, MSB first
- trans_done  in  NUM_MASTERS  per-master one-cycle end-of-transaction pulse
- approval_grant  out  NUM_MASTERS  one-hot grant, registered
- arbitor_busy  out  1  arbiter not IDLE, broadcast to all masters
- bus_busy  out  1  bus connected (CONNECT state), broadcast to all masters
- bus_owner  out  OWN_W  index of granted master, valid while approval_grant != 0
- slave_sel  out  SLAVE_LEN  captured slave select
- slave_en  out  NUM_SLAVES  one-hot decode of slave_sel, nonzero only in CONNECT
- timeout_err  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT, ADDR, CONNECT, RELEASE. All outputs registered.
- IDLE: if any approval_request, pick the first requester searching from last_owner+1 modulo NUM_MASTERS. Load bus_owner, set approval_grant[owner], go to GRANT. No request: stay.
- GRANT: one cycle for the master to see the grant. Clear shift register and bit counter. Go to ADDR.
- ADDR: shift tx_slave_select[owner] into the shift register each cycle, MSB first, for exactly SLAVE_LEN cycles. On the last bit, latch slave_sel, set slave_en[slave_sel] and bus_busy, clear the timeout counter, and go to CONNECT.
- CONNECT: count cycles. trans_done[owner]=1 goes to RELEASE. Counter reaching TIMEOUT-1 (TIMEOUT≠0) without trans_done goes to RELEASE and pulses timeout_err. trans_done and timeout in the same cycle count as normal completion, with no error.
- RELEASE: approval_grant, slave_en, bus_busy cleared. last_owner ← bus_owner. Go to IDLE. Requests are not sampled in RELEASE.
- Abort: approval_request[owner] falling in GRANT or ADDR goes to RELEASE. No slave_en pulse, no timeout_err, last_owner still updated. In CONNECT a request drop is ignored.
- trans_done from a non-owner is ignored in all states. tx_slave_select of non-owners is ignored.
- Fairness: a master that just released cannot win the next arbitration if another master is requesting.
- Reset: state IDLE, approval_grant=0, arbitor_busy=0, bus_busy=0, bus_owner=0, slave_sel=0, slave_en=0, timeout_err=0, last_owner=NUM_MASTERS-1 (master 0 has first priority). Reset in any state aborts immediately, with no RELEASE cycle.

## Timing
- Request seen in IDLE at edge k: approval_grant and arbitor_busy high after edge k. GRANT occupies cycle k+1. ADDR occupies cycles k+2 … k+1+SLAVE_LEN.
- Master drives bit MSB in the first ADDR cycle, i.e. one cycle after it first sees the grant.
- slave_en and bus_busy high from cycle k+2+SLAVE_LEN. Grant-to-connect latency is 1+SLAVE_LEN cycles.
- trans_done sampled at edge t: RELEASE in cycle t+1. slave_en and bus_busy drop after edge t. approval_grant drops after edge t+1, and IDLE is reached after edge t+1.
- Minimum back-to-back spacing: the next grant is asserted 2 cycles after the previous trans_done edge.
- Timeout counter width is $clog2(TIMEOUT+1) and does not wrap (held at terminal value until exit).

## Test plan
- Single request, NUM_MASTERS=2, SLAVE_LEN=2: master 1 requests, shifts bits 1,0 → grant=2'b10 one cycle later, slave_sel=2, slave_en=4'b0100 after 3 cycles. trans_done[1] → slave_en=0 next cycle, grant=0 the cycle after.
- Simultaneous requests from both masters after reset → master 0 granted first. Master 1 granted 2 cycles after master 0's trans_done. With both requesting continuously, grants alternate 0,1,0,1.
- Abort: master 0 drops request during the 2nd ADDR cycle → RELEASE, slave_en never nonzero, timeout_err=0, next arbitration favours master 1.
- Timeout with TIMEOUT=8 and no trans_done → timeout_err one-cycle pulse exactly 8 cycles after entering CONNECT, bus released. trans_done on the terminal cycle → no timeout_err.
- Spurious trans_done[0] while master 1 owns the bus in CONNECT → no state change, slave_en held.
- Reset asserted mid-CONNECT → next cycle all outputs 0, state IDLE, a pending request from master 1 is granted after reset deasserts, with master 0 having priority if both request.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares one serial bus among NUM_MASTERS masters. Grants round-robin,
// shifts in the owner's serial slave select (MSB first), drives a one-hot
// slave enable while connected, and releases on the owner's trans_done,
// on an optional CONNECT timeout, or when the owner drops its request
// before the connection is made.
//
// Ports
//   clk               system clock, rising edge
//   reset             synchronous, active-high
//   approval_request  per-master level request
//   tx_slave_select   per-master serial slave select, MSB first
//   trans_done        per-master end-of-transaction pulse
//   approval_grant    one-hot registered grant
//   arbitor_busy      arbiter not idle
//   bus_busy          bus connected
//   bus_owner         index of granted master
//   slave_sel         captured slave select
//   slave_en          one-hot decode of slave_sel while connected
//   timeout_err       one-cycle pulse on forced release
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | bus free, arbitrate among requesters
// S_GRANT   | grant visible to the owner for one cycle, clear shifter
// S_ADDR    | shift in SLAVE_LEN select bits from the owner
// S_CONNECT | slave enabled, wait for trans_done or timeout
// S_RELEASE | drop grant, remember last owner for round-robin
module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int SLAVE_LEN   = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_MASTERS-1:0]         approval_request,
    input  logic [NUM_MASTERS-1:0]         tx_slave_select,
    input  logic [NUM_MASTERS-1:0]         trans_done,
    output logic [NUM_MASTERS-1:0]         approval_grant,
    output logic                           arbitor_busy,
    output logic                           bus_busy,
    output logic [$clog2(NUM_MASTERS)-1:0] bus_owner,
    output logic [SLAVE_LEN-1:0]           slave_sel,
    output logic [(2**SLAVE_LEN)-1:0]      slave_en,
    output logic                           timeout_err
);

    localparam int OWN_W      = $clog2(NUM_MASTERS);
    localparam int NUM_SLAVES = 2**SLAVE_LEN;
    localparam int BIT_W      = $clog2(SLAVE_LEN + 1);
    localparam int TO_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLAVE_LEN - 1);
    localparam logic [TO_W-1:0]  TO_TERM  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ADDR,
        S_CONNECT,
        S_RELEASE
    } state_t;

    state_t state_q, state_d;

    logic [OWN_W-1:0]       last_owner_q, last_owner_d;
    logic [SLAVE_LEN-1:0]   shift_q, shift_d, shifted;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;

    logic [NUM_MASTERS-1:0] grant_d;
    logic [OWN_W-1:0]       owner_d;
    logic [SLAVE_LEN-1:0]   sel_d;
    logic [NUM_SLAVES-1:0]  en_d;
    logic                   bbusy_d;
    logic                   arb_d;
    logic                   terr_d;

    logic [OWN_W-1:0]       rr_pick;
    logic                   req_own;
    logic                   tx_own;
    logic                   done_own;

    assign req_own  = approval_request[bus_owner];
    assign tx_own   = tx_slave_select[bus_owner];
    assign done_own = trans_done[bus_owner];

    // Low SLAVE_LEN bits of {shift, new bit}: shift left, MSB first.
    assign shifted  = SLAVE_LEN'({shift_q, tx_own});

    // Round-robin: first requester starting just after the last owner.
    always_comb begin : rr_search
        logic [OWN_W-1:0] cand;
        logic             found;
        rr_pick = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = OWN_W'((int'(last_owner_q) + i) % NUM_MASTERS);
            if (!found && approval_request[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = to_cnt_q;
        grant_d      = approval_grant;
        owner_d      = bus_owner;
        sel_d        = slave_sel;
        en_d         = slave_en;
        bbusy_d      = bus_busy;
        terr_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|approval_request) begin
                    owner_d          = rr_pick;
                    grant_d          = '0;
                    grant_d[rr_pick] = 1'b1;
                    state_d          = S_GRANT;
                end
            end

            S_GRANT: begin
                shift_d   = '0;
                bit_cnt_d = '0;
                state_d   = req_own ? S_ADDR : S_RELEASE;
            end

            S_ADDR: begin
                if (!req_own) begin
                    state_d = S_RELEASE;
                end else begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        sel_d         = shifted;
                        en_d          = '0;
                        en_d[shifted] = 1'b1;
                        bbusy_d       = 1'b1;
                        to_cnt_d      = '0;
                        state_d       = S_CONNECT;
                    end
                end
            end

            S_CONNECT: begin
                // trans_done wins over a simultaneous timeout.
                if (done_own) begin
                    en_d    = '0;
                    bbusy_d = 1'b0;
                    state_d = S_RELEASE;
                end else if (TIMEOUT != 0 && to_cnt_q == TO_TERM) begin
                    en_d    = '0;
                    bbusy_d = 1'b0;
                    terr_d  = 1'b1;
                    state_d = S_RELEASE;
                end else if (TIMEOUT != 0) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_RELEASE: begin
                grant_d      = '0;
                en_d         = '0;
                bbusy_d      = 1'b0;
                last_owner_d = bus_owner;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign arb_d = (state_d != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            last_owner_q   <= OWN_W'(NUM_MASTERS - 1);
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            to_cnt_q       <= '0;
            approval_grant <= '0;
            arbitor_busy   <= 1'b0;
            bus_busy       <= 1'b0;
            bus_owner      <= '0;
            slave_sel      <= '0;
            slave_en       <= '0;
            timeout_err    <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            to_cnt_q       <= to_cnt_d;
            approval_grant <= grant_d;
            arbitor_busy   <= arb_d;
            bus_busy       <= bbusy_d;
            bus_owner      <= owner_d;
            slave_sel      <= sel_d;
            slave_en       <= en_d;
            timeout_err    <= terr_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (2 masters, 2-bit select, TIMEOUT=8).
// A transaction-level reference model tracks the current owner, the age of
// its tenure and the pending release; directed vectors, hand sequences and
// a randomized run are all compared against it and against fixed values.
module tb_bus_arbiter;

    localparam int NM = 2;
    localparam int SL = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NM-1:0] approval_request;
    logic [NM-1:0] tx_slave_select;
    logic [NM-1:0] trans_done;
    logic [NM-1:0] approval_grant;
    logic          arbitor_busy;
    logic          bus_busy;
    logic [0:0]    bus_owner;
    logic [SL-1:0] slave_sel;
    logic [3:0]    slave_en;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS(NM),
        .SLAVE_LEN  (SL),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .approval_request(approval_request),
        .tx_slave_select (tx_slave_select),
        .trans_done      (trans_done),
        .approval_grant  (approval_grant),
        .arbitor_busy    (arbitor_busy),
        .bus_busy        (bus_busy),
        .bus_owner       (bus_owner),
        .slave_sel       (slave_sel),
        .slave_en        (slave_en),
        .timeout_err     (timeout_err)
    );

    // Reference model: owner (-1 = free), age = cycles since grant,
    // rel = release cycle pending, acc = select bits gathered so far.
    int m_owner = -1;
    int m_age   = 0;
    int m_acc   = 0;
    int m_sel   = 0;
    int m_last  = NM - 1;
    bit m_rel   = 1'b0;
    bit m_terr  = 1'b0;

    function automatic bit bit_at(input logic [NM-1:0] v, input int i);
        return v[i[0]];
    endfunction

    task automatic model_step();
        m_terr = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_rel   = 1'b0;
            m_last  = NM - 1;
            m_sel   = 0;
        end else if (m_rel) begin
            m_last  = m_owner;
            m_owner = -1;
            m_rel   = 1'b0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= NM; i++) begin
                if (m_owner < 0 && bit_at(approval_request, (m_last + i) % NM)) begin
                    m_owner = (m_last + i) % NM;
                    m_age   = 0;
                    m_acc   = 0;
                end
            end
        end else if (m_age <= SL) begin
            if (!bit_at(approval_request, m_owner)) begin
                m_rel = 1'b1;
            end else begin
                if (m_age >= 1) begin
                    m_acc = m_acc * 2 + int'(bit_at(tx_slave_select, m_owner));
                    if (m_age == SL) m_sel = m_acc;
                end
                m_age++;
            end
        end else begin
            if (bit_at(trans_done, m_owner)) begin
                m_rel = 1'b1;
            end else if (m_age - (SL + 1) == TO - 1) begin
                m_rel  = 1'b1;
                m_terr = 1'b1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [NM-1:0] e_grant;
        logic [3:0]    e_en;
        logic          e_arb;
        logic          e_bb;
        e_grant = '0;
        e_en    = '0;
        e_arb   = (m_owner >= 0);
        if (e_arb) e_grant[m_owner[0]] = 1'b1;
        e_bb    = e_arb && !m_rel && (m_age >= SL + 1);
        if (e_bb) e_en[m_sel[1:0]] = 1'b1;
        chk("model_grant", int'(approval_grant), int'(e_grant));
        chk("model_arb_busy", int'(arbitor_busy), int'(e_arb));
        chk("model_bus_busy", int'(bus_busy), int'(e_bb));
        chk("model_slave_en", int'(slave_en), int'(e_en));
        chk("model_timeout_err", int'(timeout_err), int'(m_terr));
        if (e_arb) chk("model_owner", int'(bus_owner), m_owner);
        if (e_bb) chk("model_slave_sel", int'(slave_sel), m_sel);
    endtask

    task automatic tick(input logic rst, input logic [NM-1:0] req,
                        input logic [NM-1:0] tx, input logic [NM-1:0] done);
        reset            = rst;
        approval_request = req;
        tx_slave_select  = tx;
        trans_done       = done;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // One complete transaction: wait for a grant, shift sel, hold CONNECT
    // for hold+1 cycles ending with trans_done, then the release cycle.
    task automatic txn(input logic [NM-1:0] req, input logic [1:0] sel, input int hold,
                       output int owner, output int waited);
        logic [NM-1:0] txv;
        logic [NM-1:0] dn;
        owner  = -1;
        waited = 0;
        while (owner < 0 && waited < 12) begin
            tick(1'b0, req, 2'b00, 2'b00);
            waited++;
            if (approval_grant != 0) owner = approval_grant[1] ? 1 : 0;
        end
        if (owner < 0) begin
            chk("txn_grant_wait", 0, 1);
            return;
        end
        tick(1'b0, req, 2'b00, 2'b00);
        for (int b = 1; b >= 0; b--) begin
            txv = '0;
            txv[owner[0]] = sel[b[0]];
            tick(1'b0, req, txv, 2'b00);
        end
        for (int c = 0; c < hold; c++) tick(1'b0, req, 2'b00, 2'b00);
        dn = '0;
        dn[owner[0]] = 1'b1;
        tick(1'b0, req, 2'b00, dn);
        tick(1'b0, req, 2'b00, 2'b00);
    endtask

    typedef struct {
        logic [1:0] req, tx, done, grant;
        logic       arb, bb;
        logic [3:0] en;
        logic       terr;
        logic       owner;
        logic [1:0] sel;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o, w;
        int n;
        logic [NM-1:0] rq;
        logic [NM-1:0] dn;
        logic [NM-1:0] txr;
        logic          rr;

        // Master 1 alone, select bits 1,0 -> slave 2; done, release, idle.
        vecs[0] = '{2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
        vecs[1] = '{2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
        vecs[2] = '{2'b10, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
        vecs[3] = '{2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2};
        vecs[4] = '{2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2};
        vecs[5] = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2};
        vecs[6] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[7] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};

        tick(1'b1, 2'b00, 2'b00, 2'b00);
        tick(1'b1, 2'b00, 2'b00, 2'b00);
        chk("rst_grant", int'(approval_grant), 0);
        chk("rst_arb_busy", int'(arbitor_busy), 0);
        chk("rst_bus_busy", int'(bus_busy), 0);
        chk("rst_owner", int'(bus_owner), 0);
        chk("rst_slave_sel", int'(slave_sel), 0);
        chk("rst_slave_en", int'(slave_en), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);

        for (int i = 0; i < 8; i++) begin
            tick(1'b0, vecs[i].req, vecs[i].tx, vecs[i].done);
            chk($sformatf("vec%0d_grant", i), int'(approval_grant), int'(vecs[i].grant));
            chk($sformatf("vec%0d_arb_busy", i), int'(arbitor_busy), int'(vecs[i].arb));
            chk($sformatf("vec%0d_bus_busy", i), int'(bus_busy), int'(vecs[i].bb));
            chk($sformatf("vec%0d_slave_en", i), int'(slave_en), int'(vecs[i].en));
            chk($sformatf("vec%0d_timeout_err", i), int'(timeout_err), int'(vecs[i].terr));
            if (vecs[i].grant != 0)
                chk($sformatf("vec%0d_owner", i), int'(bus_owner), int'(vecs[i].owner));
            if (vecs[i].en != 0)
                chk($sformatf("vec%0d_slave_sel", i), int'(slave_sel), int'(vecs[i].sel));
        end

        // Both masters requesting after reset: 0 first, then alternate.
        tick(1'b1, 2'b11, 2'b00, 2'b00);
        txn(2'b11, 2'b01, 1, o, w);
        chk("alt_owner0", o, 0);
        txn(2'b11, 2'b11, 0, o, w);
        chk("alt_owner1", o, 1);
        chk("b2b_gap_cycles", w, 1);
        txn(2'b11, 2'b10, 2, o, w);
        chk("alt_owner2", o, 0);
        txn(2'b11, 2'b00, 0, o, w);
        chk("alt_owner3", o, 1);

        // Abort: master 0 drops its request in the second ADDR cycle.
        tick(1'b1, 2'b00, 2'b00, 2'b00);
        tick(1'b0, 2'b01, 2'b00, 2'b00);
        chk("abort_grant", int'(approval_grant), 1);
        tick(1'b0, 2'b01, 2'b00, 2'b00);
        tick(1'b0, 2'b01, 2'b01, 2'b00);
        tick(1'b0, 2'b00, 2'b00, 2'b00);
        chk("abort_slave_en", int'(slave_en), 0);
        chk("abort_bus_busy", int'(bus_busy), 0);
        chk("abort_timeout_err", int'(timeout_err), 0);
        chk("abort_release_grant", int'(approval_grant), 1);
        tick(1'b0, 2'b11, 2'b00, 2'b00);
        chk("abort_idle_grant", int'(approval_grant), 0);
        tick(1'b0, 2'b11, 2'b00, 2'b00);
        chk("abort_fair_next", int'(approval_grant), 2);
        tick(1'b0, 2'b00, 2'b00, 2'b00);
        tick(1'b0, 2'b00, 2'b00, 2'b00);

        // Timeout with no trans_done.
        tick(1'b0, 2'b01, 2'b00, 2'b00);
        tick(1'b0, 2'b01, 2'b00, 2'b00);
        tick(1'b0, 2'b01, 2'b01, 2'b00);
        tick(1'b0, 2'b01, 2'b00, 2'b00);
        chk("to_connected", int'(bus_busy), 1);
        n = 0;
        while (n < 20 && !timeout_err) begin
            tick(1'b0, 2'b01, 2'b00, 2'b00);
            n++;
        end
        chk("to_cycles", n, 8);
        chk("to_slave_en", int'(slave_en), 0);
        chk("to_release_grant", int'(approval_grant), 1);
        tick(1'b0, 2'b00, 2'b00, 2'b00);
        chk("to_pulse_width", int'(timeout_err), 0);
        chk("to_idle_grant", int'(approval_grant), 0);

        // trans_done on the terminal CONNECT cycle: normal completion.
        tick(1'b0, 2'b01, 2'b00, 2'b00);
        tick(1'b0, 2'b01, 2'b00, 2'b00);
        tick(1'b0, 2'b01, 2'b01, 2'b00);
        tick(1'b0, 2'b01, 2'b00, 2'b00);
        for (int c = 0; c < TO - 1; c++) tick(1'b0, 2'b01, 2'b00, 2'b00);
        tick(1'b0, 2'b01, 2'b00, 2'b01);
        chk("term_done_timeout_err", int'(timeout_err), 0);
        chk("term_done_slave_en", int'(slave_en), 0);
        chk("term_done_grant", int'(approval_grant), 1);
        tick(1'b0, 2'b00, 2'b00, 2'b00);

        // Spurious trans_done from master 0 while master 1 is connected.
        tick(1'b0, 2'b10, 2'b00, 2'b00);
        tick(1'b0, 2'b10, 2'b00, 2'b00);
        tick(1'b0, 2'b10, 2'b10, 2'b00);
        tick(1'b0, 2'b10, 2'b10, 2'b00);
        tick(1'b0, 2'b10, 2'b00, 2'b01);
        chk("spur_slave_en", int'(slave_en), 8);
        chk("spur_bus_busy", int'(bus_busy), 1);
        chk("spur_grant", int'(approval_grant), 2);
        tick(1'b0, 2'b10, 2'b00, 2'b10);
        tick(1'b0, 2'b00, 2'b00, 2'b00);

        // Reset in the middle of CONNECT.
        tick(1'b0, 2'b10, 2'b00, 2'b00);
        tick(1'b0, 2'b10, 2'b00, 2'b00);
        tick(1'b0, 2'b10, 2'b00, 2'b00);
        tick(1'b0, 2'b10, 2'b10, 2'b00);
        tick(1'b0, 2'b10, 2'b00, 2'b00);
        chk("mid_rst_pre_en", int'(slave_en), 2);
        tick(1'b1, 2'b10, 2'b00, 2'b00);
        chk("mid_rst_grant", int'(approval_grant), 0);
        chk("mid_rst_arb_busy", int'(arbitor_busy), 0);
        chk("mid_rst_bus_busy", int'(bus_busy), 0);
        chk("mid_rst_slave_en", int'(slave_en), 0);
        chk("mid_rst_slave_sel", int'(slave_sel), 0);
        tick(1'b0, 2'b10, 2'b00, 2'b00);
        chk("post_rst_grant_m1", int'(approval_grant), 2);
        tick(1'b1, 2'b11, 2'b00, 2'b00);
        tick(1'b0, 2'b11, 2'b00, 2'b00);
        chk("post_rst_grant_m0", int'(approval_grant), 1);
        tick(1'b0, 2'b00, 2'b00, 2'b00);
        tick(1'b0, 2'b00, 2'b00, 2'b00);

        // Randomized traffic against the model.
        rq = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            rq  = rq ^ {($urandom_range(7) == 0), ($urandom_range(7) == 0)};
            dn  = {($urandom_range(4) == 0), ($urandom_range(4) == 0)};
            txr = 2'($urandom);
            rr  = ($urandom_range(255) == 0);
            tick(rr, rq, txr, dn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
